// File: rtl/gmii_rx_frame_ctrl.sv
// GMII receive frame controller.
// Strips preamble/SFD, forwards frame bytes with start/end markers, reports
// frame length and error status, and flags false carrier and discarded bursts.
module gmii_rx_frame_ctrl #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        rx_clk,
  input  logic        rst_n,
  input  logic [7:0]  rxd,
  input  logic        rx_dv,
  input  logic        rx_er,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sof,
  output logic        rx_eof,
  output logic [10:0] rx_frame_len,
  output logic        rx_frame_err,
  output logic        false_carrier,
  output logic        rx_drop
);

  localparam logic [10:0] MIN_L   = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L   = 11'(MAX_LEN);
  localparam logic [10:0] CNT_SAT = 11'd2047;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    DATA     = 3'd2,
    EXTEND   = 3'd3,
    DROP     = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic [10:0] r_cnt;
  logic [10:0] w_cnt_nx;
  logic        r_err;
  logic        w_err_nx;
  logic        w_enter_data;
  logic        w_eof_err;

  logic [7:0]  r_data,  w_data_nx;
  logic        r_valid, w_valid_nx;
  logic        r_sof,   w_sof_nx;
  logic        r_eof,   w_eof_nx;
  logic [10:0] r_len,   w_len_nx;
  logic        r_ferr,  w_ferr_nx;
  logic        r_fc,    w_fc_nx;
  logic        r_drop,  w_drop_nx;

  // Classification of a byte seen while no frame is active (also used for
  // the first byte of a burst continuation out of carrier extension).
  function automatic state_t idle_rule(input logic [7:0] d);
    state_t s;
    case (d)
      8'h55:   s = PREAMBLE;
      8'hD5:   s = DATA;
      default: s = DROP;
    endcase
    return s;
  endfunction

  // Byte counter increment that sticks at the 11-bit ceiling.
  function automatic logic [10:0] sat_inc(input logic [10:0] c);
    return (c == CNT_SAT) ? c : c + 11'd1;
  endfunction

  assign w_eof_err    = r_err | (r_cnt < MIN_L) | (r_cnt > MAX_L);
  assign w_enter_data = (w_state_nx == DATA) && (r_state != DATA);

  // Next-state, counter/error update and next output values.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_err_nx   = r_err;
    w_data_nx  = r_data;
    w_valid_nx = 1'b0;
    w_sof_nx   = 1'b0;
    w_eof_nx   = 1'b0;
    w_len_nx   = 11'd0;
    w_ferr_nx  = 1'b0;
    w_fc_nx    = 1'b0;
    w_drop_nx  = 1'b0;
    case (r_state)
      IDLE: begin
        if (rx_dv) begin
          w_state_nx = idle_rule(rxd);
        end else if (rx_er && (rxd == 8'h0E)) begin
          w_fc_nx = 1'b1;
        end else begin
          w_state_nx = IDLE;
        end
      end
      PREAMBLE: begin
        if (rx_dv) begin
          w_state_nx = idle_rule(rxd);
        end else begin
          w_state_nx = IDLE;
        end
      end
      DATA: begin
        if (rx_dv) begin
          w_cnt_nx = sat_inc(r_cnt);
          if (rx_er) begin
            w_err_nx = 1'b1;
          end else begin
            w_err_nx = r_err;
          end
          if (r_cnt < MAX_L) begin
            w_valid_nx = 1'b1;
            w_data_nx  = rxd;
            w_sof_nx   = (r_cnt == 11'd0);
          end else begin
            w_valid_nx = 1'b0;
          end
        end else if (rx_er && (rxd == 8'h0F)) begin
          // Carrier extension: end-of-frame is reported when it finishes.
          w_state_nx = EXTEND;
        end else begin
          w_eof_nx   = 1'b1;
          w_len_nx   = r_cnt;
          w_ferr_nx  = w_eof_err;
          w_state_nx = IDLE;
        end
      end
      EXTEND: begin
        if (rx_dv) begin
          // Burst continuation: close this frame, classify the new byte.
          w_eof_nx   = 1'b1;
          w_len_nx   = r_cnt;
          w_ferr_nx  = w_eof_err;
          w_state_nx = idle_rule(rxd);
        end else if (rx_er) begin
          if (rxd == 8'h1F) begin
            w_err_nx = 1'b1;
          end else begin
            w_err_nx = r_err;
          end
        end else begin
          w_eof_nx   = 1'b1;
          w_len_nx   = r_cnt;
          w_ferr_nx  = w_eof_err;
          w_state_nx = IDLE;
        end
      end
      DROP: begin
        if (!rx_dv && !(rx_er && (rxd == 8'h0F))) begin
          w_drop_nx  = 1'b1;
          w_state_nx = IDLE;
        end else begin
          w_state_nx = DROP;
        end
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  // State, frame counter and sticky error registers; counter/error restart
  // whenever a new frame body begins.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 11'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (w_enter_data) begin
        r_cnt <= 11'd0;
        r_err <= 1'b0;
      end else begin
        r_cnt <= w_cnt_nx;
        r_err <= w_err_nx;
      end
    end
  end

  // Registered outputs, one rx_clk behind the sampled inputs.
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= 8'd0;
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;
      r_len   <= 11'd0;
      r_ferr  <= 1'b0;
      r_fc    <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_data  <= w_data_nx;
      r_valid <= w_valid_nx;
      r_sof   <= w_sof_nx;
      r_eof   <= w_eof_nx;
      r_len   <= w_len_nx;
      r_ferr  <= w_ferr_nx;
      r_fc    <= w_fc_nx;
      r_drop  <= w_drop_nx;
    end
  end

  assign rx_data       = r_data;
  assign rx_valid      = r_valid;
  assign rx_sof        = r_sof;
  assign rx_eof        = r_eof;
  assign rx_frame_len  = r_len;
  assign rx_frame_err  = r_ferr;
  assign false_carrier = r_fc;
  assign rx_drop       = r_drop;

endmodule
